// File: rtl/spi_cfg_sequencer_if.sv
// spi_cfg_sequencer_if: host push, status and SPI writer signals of the config sequencer.
interface spi_cfg_sequencer_if #(parameter int AW = 3);
  logic          wr_valid;
  logic [63:0]   wr_data;
  logic          wr_ready;
  logic          start;
  logic          swr_in;
  logic          spi_en;
  logic [63:0]   spi_data;
  logic [63:0]   rb_in;
  logic [63:0]   rb_last;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          err_verify;
  logic [7:0]    frame_cnt;
  logic [AW:0]   fifo_level;
  modport slave (
    input  wr_valid, wr_data, start, swr_in, rb_in,
    output wr_ready, spi_en, spi_data, rb_last, busy, done, err_timeout, err_verify, frame_cnt, fifo_level
  );
  modport master (
    output wr_valid, wr_data, start, swr_in, rb_in,
    input  wr_ready, spi_en, spi_data, rb_last, busy, done, err_timeout, err_verify, frame_cnt, fifo_level
  );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: FIFO-fed launcher of 64-bit config words into the SPI frame writer.
// Optional readback verify with bounded re-sends is enabled by defining SPI_SEQ_VERIFY_EN.
module spi_cfg_sequencer #(
  parameter int NDATA     = 48,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input logic               clk,
  input logic               rst_n,
  spi_cfg_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, WAIT_LOW = 3'd2, WAIT_HIGH = 3'd3, CHECK = 3'd4, FIN = 3'd5;
  localparam int TW = $clog2(TIMEOUT + 1);
  if (TIMEOUT < 2 * NDATA + 8 || DEPTH != (1 << AW) || MAX_RETRY < 1) begin : g_bad_cfg
    $error("spi_cfg_sequencer: inconsistent TIMEOUT/NDATA/DEPTH/AW/MAX_RETRY");
  end
  logic [2:0]    state, nxt;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level;
  logic [TW-1:0] tmo;
  logic [63:0]   spi_q, rb_q, nxt_head;
  logic [7:0]    fcnt;
  logic          push, pop, go, waiting, tmo_hit, last, retry, err_t;
  assign push     = bus.wr_valid && bus.wr_ready;
  assign go       = state == IDLE && bus.start;
  assign waiting  = state == WAIT_LOW || state == WAIT_HIGH;
  assign tmo_hit  = waiting && tmo == TW'(TIMEOUT);
  assign pop      = state == CHECK && !retry;
  assign last     = pop && level == (AW+1)'(1) && !push;
  // A word pushed in the same cycle as the pop that empties the FIFO is forwarded straight to the next launch.
  assign nxt_head = !pop ? mem[rd_ptr]
                  : (push && wr_ptr == rd_ptr + AW'(1)) ? bus.wr_data : mem[rd_ptr + AW'(1)];
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = !bus.start ? IDLE : (level == '0 ? FIN : LAUNCH);
      LAUNCH:    nxt = WAIT_LOW;
      WAIT_LOW:  nxt = tmo_hit ? FIN : (!bus.swr_in ? WAIT_HIGH : WAIT_LOW);
      WAIT_HIGH: nxt = tmo_hit ? FIN : (bus.swr_in ? CHECK : WAIT_HIGH);
      CHECK:     nxt = last ? FIN : LAUNCH;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= tmo_hit ? wr_ptr + AW'(push) : rd_ptr + AW'(pop);
      level  <= tmo_hit ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmo   <= '0;
      spi_q <= '0;
      rb_q  <= '0;
      err_t <= 1'b0;
      fcnt  <= '0;
    end else begin
      state <= nxt;
      tmo   <= state == LAUNCH ? '0 : tmo + TW'(waiting);
      if (nxt == LAUNCH) spi_q <= nxt_head;
      if (state == WAIT_HIGH && bus.swr_in && !tmo_hit) rb_q <= bus.rb_in;
      err_t <= go ? 1'b0 : err_t | tmo_hit;
      fcnt  <= go ? '0 : fcnt + 8'(pop);
    end
`ifdef SPI_SEQ_VERIFY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [NDATA-1:0] rev;
  logic [RW-1:0]    retry_cnt;
  logic             bad, err_v;
  // The first bit shifted out returns in the readback MSB.
  for (genvar i = 0; i < NDATA; i++) begin : g_rev
    assign rev[i] = spi_q[NDATA-1-i];
  end
  assign bad            = state == CHECK && bus.rb_in[NDATA-1:0] != rev;
  assign retry          = bad && retry_cnt != RW'(MAX_RETRY);
  assign bus.err_verify = err_v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retry_cnt <= '0;
      err_v     <= 1'b0;
    end else begin
      retry_cnt <= (pop || go || tmo_hit) ? '0 : retry_cnt + RW'(retry);
      err_v     <= go ? 1'b0 : err_v | (bad && !retry);
    end
`else
  assign retry          = 1'b0;
  assign bus.err_verify = 1'b0;
`endif
  assign bus.wr_ready    = level != (AW+1)'(DEPTH);
  assign bus.spi_en      = state == LAUNCH;
  assign bus.spi_data    = spi_q;
  assign bus.rb_last     = rb_q;
  assign bus.busy        = state inside {LAUNCH, WAIT_LOW, WAIT_HIGH, CHECK};
  assign bus.done        = state == FIN;
  assign bus.err_timeout = err_t;
  assign bus.frame_cnt   = fcnt;
  assign bus.fifo_level  = level;
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: directed and randomized checks of spi_cfg_sequencer against a queue-based model
// and a behavioural SPI writer that echoes each frame bit-reversed.
module tb_spi_cfg_sequencer;
  localparam int DEPTH = 8, TIMEOUT = 255, NDATA = 48;
  logic clk = 1'b0, rst_n = 1'b1;
  int n_chk = 0, n_fail = 0, mlev = 0, lo_fix = 0, hi_fix = 0;
  bit stuck = 1'b0;
  logic [63:0] exp_q[$], launches[$];
  logic [63:0] last_rb = '0;
  spi_cfg_sequencer_if #(.AW(3)) bus();
  spi_cfg_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] echo(input logic [63:0] w);
    logic [63:0] r = '0;
    for (int i = 0; i < NDATA; i++) r[NDATA-1-i] = w[i];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Writer model: swr drops for the readback phase, then rises with the bit-reversed frame on rb_in.
  initial begin
    logic [63:0] w;
    int lo, hi;
    bus.swr_in = 1'b1;
    bus.rb_in  = '0;
    forever begin
      @(posedge clk);
      if (bus.spi_en) begin
        w = bus.spi_data;
        launches.push_back(w);
        if (!stuck) begin
          lo = hi_fix != 0 ? lo_fix : int'($urandom_range(0, 4));
          hi = hi_fix != 0 ? hi_fix : int'($urandom_range(1, 12));
          repeat (lo) @(posedge clk);
          #1 bus.swr_in = 1'b0;
          repeat (hi) @(posedge clk);
          #1 bus.rb_in = echo(w);
          bus.swr_in = 1'b1;
          if (bus.busy) chk("spi_data_hold", bus.spi_data, w);
        end
      end
    end
  end
  task automatic push(input logic [63:0] d, input bit acc);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    if (acc) begin
      exp_q.push_back(d);
      mlev++;
    end
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
    @(posedge clk);
    #1 chk("done_pulse_width", 64'(bus.done), 64'd0);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
  endtask
  task automatic check_seq();
    logic [63:0] d;
    chk("launch_count", 64'(launches.size()), 64'(exp_q.size()));
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(exp_q.size() % 256));
    while (exp_q.size() > 0 && launches.size() > 0) begin
      d = exp_q.pop_front();
      chk("launch_word", launches.pop_front(), d);
      last_rb = echo(d);
    end
    chk("rb_last", bus.rb_last, last_rb);
    chk("fifo_level_end", 64'(bus.fifo_level), 64'd0);
    chk("err_timeout_clear", 64'(bus.err_timeout), 64'd0);
    chk("err_verify_clear", 64'(bus.err_verify), 64'd0);
    exp_q.delete();
    launches.delete();
    mlev = 0;
  endtask
  task automatic empty_start(input string tag);
    pulse_start();
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk({tag, "_no_launch"}, 64'(launches.size()), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'd0);
  endtask
  initial begin
    int cyc, n;
    logic [63:0] d;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_spi_en", 64'(bus.spi_en), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_fifo_level", 64'(bus.fifo_level), 64'd0);
    chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("rst_err_timeout", 64'(bus.err_timeout), 64'd0);
    chk("rst_err_verify", 64'(bus.err_verify), 64'd0);
    chk("rst_rb_last", bus.rb_last, 64'd0);
    chk("rst_spi_data", bus.spi_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Two directed words.
    push(64'h0000_A5A5_0000_0001, mlev < DEPTH);
    push(64'h0000_FFFF_0000_0002, mlev < DEPTH);
    chk("level_two", 64'(bus.fifo_level), 64'd2);
    pulse_start();
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check_seq();
    empty_start("empty");
    chk("empty_rb_kept", bus.rb_last, last_rb);
    // Overflow: ninth word dropped, then refill during the sequence.
    for (int i = 0; i < 9; i++) push({$urandom, $urandom}, mlev < DEPTH);
    chk("full_level", 64'(bus.fifo_level), 64'd8);
    chk("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    pulse_start();
    cyc = 0;
    while (bus.wr_ready !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("refill_ready", 64'(bus.wr_ready), 64'd1);
    push({$urandom, $urandom}, 1'b1);
    wait_done(cyc);
    check_seq();
    // Random sequences with random writer timing.
    repeat (4) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) push({$urandom, $urandom}, mlev < DEPTH);
      chk("rand_level", 64'(bus.fifo_level), 64'(n));
      pulse_start();
      wait_done(cyc);
      check_seq();
    end
    // Stuck writer: timeout, flush, no frame credited.
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) push({$urandom, $urandom}, mlev < DEPTH);
    pulse_start();
    wait_done(cyc);
    chk("timeout_window", 64'(cyc >= TIMEOUT && cyc <= TIMEOUT + 4), 64'd1);
    chk("timeout_flag", 64'(bus.err_timeout), 64'd1);
    chk("timeout_flush", 64'(bus.fifo_level), 64'd0);
    chk("timeout_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("timeout_rb_kept", bus.rb_last, last_rb);
    chk("timeout_launches", 64'(launches.size()), 64'd1);
    if (launches.size() > 0) chk("timeout_word", launches[0], exp_q[0]);
    launches.delete();
    exp_q.delete();
    mlev = 0;
    stuck = 1'b0;
    push({$urandom, $urandom}, mlev < DEPTH);
    pulse_start();
    wait_done(cyc);
    check_seq();
    // Asynchronous reset in the middle of the readback phase.
    lo_fix = 0;
    hi_fix = 60;
    push({$urandom, $urandom}, mlev < DEPTH);
    push({$urandom, $urandom}, mlev < DEPTH);
    pulse_start();
    cyc = 0;
    while (bus.swr_in !== 1'b0 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("reached_readback", 64'(bus.swr_in), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_spi_en", 64'(bus.spi_en), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_fifo_level", 64'(bus.fifo_level), 64'd0);
    chk("midrst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("midrst_rb_last", bus.rb_last, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    while (bus.swr_in !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    repeat (3) @(posedge clk);
    #1 chk("midrst_launches", 64'(launches.size()), 64'd1);
    launches.delete();
    exp_q.delete();
    mlev = 0;
    hi_fix = 0;
    empty_start("post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Upstream feeder for the SPI frame writer. It buffers host-supplied 64-bit config words in a small FIFO and, on a start strobe, launches them one per frame into the writer.
- It tracks each frame's completion from the writer's swr line, captures the writer's readback, and reports done, timeout and verify status to the host wire/trigger logic.

Parameters:
- NDATA, 48: bits per frame; must match the writer.
- DEPTH, 8: FIFO depth in words; must be a power of 2.
- AW, 3: log2(DEPTH).
- TIMEOUT, 255: maximum cycles allowed per frame from launch to swr rising; must be at least 2*NDATA+8.
- MAX_RETRY, 3: re-sends per word on verify mismatch (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  host word valid.
- wr_data  in  64  host config word.
- wr_ready  out  1  FIFO can accept a word (not full).
- start  in  1  one-cycle strobe: begin sending the FIFO contents.
- swr_in  in  1  writer's swr output (low only during its readback phase).
- spi_en  out  1  frame launch pulse to the writer's en.
- spi_data  out  64  word to the writer's masterdata.
- rb_in  in  64  writer's datareadback.
- rb_last  out  64  readback of the most recent completed frame.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence.
- err_timeout  out  1  sticky timeout flag.
- err_verify  out  1  sticky verify-fail flag.
- frame_cnt  out  8  frames completed this sequence; wraps at 255.
- fifo_level  out  AW+1  words held.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except wr_ready=1. FIFO emptied, state IDLE. Reset mid-frame drops spi_en immediately. The writer is reset by its own reset.
- FIFO: a word is written when wr_valid && wr_ready. Writes are accepted while busy, and late words are sent in the same sequence. wr_valid while full is dropped. A pop and a push in the same cycle leave fifo_level unchanged.
- spi_data always shows the FIFO head, registered at LAUNCH. It is held stable through WAIT_HIGH, because the writer indexes it combinationally while shifting.
- FSM:
  - IDLE: busy=0. On start, clear err_timeout, err_verify and frame_cnt, set busy=1. If the FIFO is empty, pulse done next cycle and go to IDLE; otherwise go to LAUNCH. start while busy is ignored.
  - LAUNCH: spi_en=1 for exactly 1 cycle, clear the timeout counter, go to WAIT_LOW.
  - WAIT_LOW: wait for swr_in==0.
  - WAIT_HIGH: wait for swr_in==1. On that cycle capture rb_in into rb_last, go to CHECK.
  - CHECK: pop the head, increment frame_cnt. If the FIFO is now empty, go to FIN; else go to LAUNCH.
  - FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Timeout: the counter runs in WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT: set err_timeout, flush the FIFO, go to FIN. rb_last and frame_cnt are not updated for the aborted frame.
- Gap: minimum 1 cycle of writer IDLE between frames. The LAUNCH after CHECK guarantees the writer has returned to IDLE before en is seen.
- Nominal frame: 1 + NDATA + 5 + NDATA + 1 writer cycles plus 3 sequencer cycles.

Optional Feature:
- Macro: SPI_SEQ_VERIFY_EN.
- When defined, CHECK compares rb_in[NDATA-1:0] against the bit-reverse of spi_data[NDATA-1:0] (first bit shifted out lands in the MSB of the readback).
  - On mismatch with retries remaining: no pop, go to LAUNCH with the same word.
  - After MAX_RETRY failed re-sends: set err_verify, pop, continue.
  - The retry counter clears on each pop.
- When undefined: no compare is done, err_verify is tied to 0, and rb_last is still captured.

Test Plan:
- Push 2 words (0x0000_A5A5_0000_0001, 0x0000_FFFF_0000_0002), then pulse start. Required: 2 spi_en pulses, spi_data matches each word during its frame, done 1 cycle after the second CHECK, frame_cnt=2, fifo_level=0.
- start with an empty FIFO -> done pulses on the next cycle, frame_cnt=0, no spi_en.
- Hold swr_in=1 after launch (writer stuck) -> err_timeout=1 after 255 cycles, FIFO flushed, done pulse, frame_cnt=0.
- Push 9 words with DEPTH=8 -> the 9th is dropped, wr_ready=0, fifo_level=8. Pushing during the sequence refills and the extra word is sent.
- With SPI_SEQ_VERIFY_EN and a writer model that returns a corrupted readback -> the same word is launched 4 times, err_verify=1, then the sequence continues. With a correct echo, there are no retries.
- Assert rst_n low mid-WAIT_HIGH -> spi_en, busy and fifo_level go to 0 immediately. After release, the next start with an empty FIFO gives done only.
